sprite_draw_engine: RTL and testbench
=====================================

Name: sprite_draw_engine

Overview:
Responder side of the movement FSM's draw handshake. Accepts drawBG / drawChar requests with the sprite's (X,Y) location. Scans the sprite-sized box, fetching pixels from the background ROM or the character ROM, and issues one VGA-adapter plot per pixel. Reports completion with doneBG / doneChar. Sits between the movement logic and the 320x240 VGA adapter.

Parameters:
SPR_W, 16, sprite width in pixels (power of 2, 2..32)
SPR_H, 16, sprite height in pixels (power of 2, 2..32)
ANCHOR_X, 8, column offset of the (X,Y) anchor inside the sprite; left edge = X - ANCHOR_X
ANCHOR_Y, 15, row offset of the anchor; top edge = Y - ANCHOR_Y
COLOUR_W, 9, colour width in bits
TRANSPARENT, 9'h1FF, character colour that is not plotted (only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
drawBG  in  1  request: restore background under the sprite box
drawChar  in  1  request: draw the character sprite
xCoordinate  in  9  sprite anchor X (0..319)
yCoordinate  in  8  sprite anchor Y (0..239)
doneBG  out  1  one-cycle pulse: background restore complete
doneChar  out  1  one-cycle pulse: character draw complete
bg_addr  out  17  background ROM address = y*320 + x
bg_data  in  COLOUR_W  background ROM data, 1-cycle read latency
spr_addr  out  log2(SPR_W*SPR_H)  character ROM address = row*SPR_W + col
spr_data  in  COLOUR_W  character ROM data, 1-cycle read latency
vga_x  out  9  plot X
vga_y  out  8  plot Y
vga_colour  out  COLOUR_W  plot colour
plot  out  1  write strobe to the VGA adapter

Behaviour:
- Reset: state IDLE. plot, doneBG, doneChar = 0. vga_x, vga_y, vga_colour, bg_addr, spr_addr = 0. Reset mid-scan aborts with no done pulse.
- States:
  - IDLE: a request is sampled high at edge E0. Latch the anchor and the source (BG wins if both requests are high). Clear col and row. Go to SCAN.
  - SCAN: one pixel per cycle, col fastest. Pixel i's address is driven in cycle E0+1+i. When the last pixel (i = SPR_W*SPR_H-1) is issued, go to FLUSH.
  - FLUSH: two cycles to drain the pipeline, then DONE.
  - DONE: pulse the matching done for exactly one cycle, then go to HOLD.
  - HOLD: wait until both requests are low, then go to IDLE. This prevents a retrigger while the mover still holds its request.
- Pipeline: ROM data is valid one cycle after the address. The vga_* outputs and plot are registered, so pixel i is plotted in cycle E0+3+i. With N = SPR_W*SPR_H, the last plot is in cycle E0+N+2 and done is in cycle E0+N+3.
- Coordinate arithmetic:
  - Screen pixel px = X - ANCHOR_X + col, py = Y - ANCHOR_Y + row.
  - Compute px in 10 bits and py in 9 bits, signed.
  - If px<0, px>319, py<0 or py>239, suppress plot and force bg_addr to 0; the scan timing is unchanged.
- Anchor inputs are sampled only at E0; changes during a scan are ignored.
- While not in IDLE, new or changed requests are ignored until HOLD clears.

Optional Feature:
SPRITE_TRANSPARENCY_EN
- Defined: in character mode, a pixel whose spr_data equals TRANSPARENT has plot = 0, and the background shows through. Background mode is unaffected.
- Undefined: every in-screen pixel is plotted, and TRANSPARENT is unused.

Decomposition:
- Package sprite_draw_pkg holds:
  - SCREEN_W = 320 and SCREEN_H = 240
  - the COLOUR_W default
  - the bg_addr width
  - the state enum {IDLE, SCAN, FLUSH, DONE, HOLD}
  - the source enum {SRC_BG, SRC_CHAR}
- One sub-module, sprite_scan_counter: col/row counter with clear, enable and a last-pixel flag.
- FSM, address generation, clipping and the output registers stay in the top module.

Test Plan (SPR_W=SPR_H=4, ANCHOR_X=ANCHOR_Y=0 unless stated):
- drawBG held high with X=96, Y=100; ROM returns 9'h0AA:
  - 16 plots in consecutive cycles E0+3..E0+18, (96,100),(97,100)...(99,103), colour 9'h0AA
  - first bg_addr = 32096
  - doneBG pulses once at E0+19; no second scan while drawBG stays high; drawBG dropped at E0+20 -> IDLE
- drawChar with X=0, Y=0, ANCHOR_X=ANCHOR_Y=2:
  - only the pixels with px,py >= 0 are plotted (4 plots, at (0,0),(1,0),(0,1),(1,1))
  - doneChar still at E0+19
- X=318, Y=238, drawChar: only col 0..1 and row 0..1 are plotted (4 plots); no writes with x>319 or y>239.
- drawBG and drawChar rising together: background scan (bg_addr active), doneBG only, doneChar never pulses.
- reset asserted at E0+8 mid-scan: plot = 0 next cycle, no done pulse, state IDLE; a later drawChar completes normally.
- SPRITE_TRANSPARENCY_EN defined, spr_data = TRANSPARENT for even addresses: exactly 8 of 16 plots, all at odd columns; with the macro undefined, 16 plots.

Source files
------------

// File: rtl/sprite_draw_pkg.sv
// Shared screen geometry, widths and state/source encodings for the sprite draw engine.
package sprite_draw_pkg;

  localparam int SCREEN_W     = 320;
  localparam int SCREEN_H     = 240;
  localparam int COLOUR_W_DEF = 9;
  localparam int BG_ADDR_W    = 17;

  typedef enum logic [2:0] {IDLE, SCAN, FLUSH, DONE, HOLD} state_t;
  typedef enum logic {SRC_BG, SRC_CHAR} src_t;

  // px/py are two's complement; the sign bit catches pixels left of / above the screen.
  function automatic logic on_screen(input logic [9:0] px, input logic [8:0] py);
    return !px[9] && !py[8] && (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Column/row scan counter over the sprite box, column fastest, with a last-pixel flag.
module sprite_scan_counter #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  localparam int CW = $clog2(SPR_W),
  localparam int RW = $clog2(SPR_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  // Power-of-two dimensions let both counters wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      col <= col + 1'b1;
      if (&col) row <= row + 1'b1;
    end
  end

  assign last = (&col) && (&row);

endmodule

// File: rtl/sprite_draw_engine.sv
// Scans a sprite box from the background or character ROM and plots it to the VGA adapter.
// Optional transparency is enabled by the SPRITE_TRANSPARENCY_EN macro.
module sprite_draw_engine
  import sprite_draw_pkg::*;
#(
  parameter int          SPR_W       = 16,
  parameter int          SPR_H       = 16,
  parameter int          ANCHOR_X    = 8,
  parameter int          ANCHOR_Y    = 15,
  parameter int          COLOUR_W    = COLOUR_W_DEF,
  parameter int unsigned TRANSPARENT = 'h1FF,
  localparam int SA_W = $clog2(SPR_W * SPR_H)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 drawBG,
  input  logic                 drawChar,
  input  logic [8:0]           xCoordinate,
  input  logic [7:0]           yCoordinate,
  output logic                 doneBG,
  output logic                 doneChar,
  output logic [BG_ADDR_W-1:0] bg_addr,
  input  logic [COLOUR_W-1:0]  bg_data,
  output logic [SA_W-1:0]      spr_addr,
  input  logic [COLOUR_W-1:0]  spr_data,
  output logic [8:0]           vga_x,
  output logic [7:0]           vga_y,
  output logic [COLOUR_W-1:0]  vga_colour,
  output logic                 plot
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam logic [9:0] AX = 10'(ANCHOR_X);
  localparam logic [8:0] AY = 9'(ANCHOR_Y);

  if ((SPR_W & (SPR_W - 1)) != 0 || (SPR_H & (SPR_H - 1)) != 0) begin : g_bad_size
    $error("sprite_draw_engine: SPR_W and SPR_H must be powers of two");
  end
  if (64'(TRANSPARENT) >= (64'd1 << COLOUR_W)) begin : g_bad_transparent
    $error("sprite_draw_engine: TRANSPARENT does not fit in COLOUR_W bits");
  end

  state_t     state;
  src_t       src;
  logic [8:0] anc_x;
  logic [7:0] anc_y;
  logic       flush_cnt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last;

  logic req, start, scanning;
  assign req      = drawBG | drawChar;
  assign start    = (state == IDLE) && req;
  assign scanning = (state == SCAN);

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .clear  (start),
    .enable (scanning),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  logic [9:0] px;
  logic [8:0] py;
  logic       pix_on;
  assign px     = {1'b0, anc_x} - AX + 10'(col);
  assign py     = {1'b0, anc_y} - AY + 9'(row);
  assign pix_on = on_screen(px, py);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      src       <= SRC_BG;
      anc_x     <= '0;
      anc_y     <= '0;
      flush_cnt <= 1'b0;
      doneBG    <= 1'b0;
      doneChar  <= 1'b0;
    end else begin
      doneBG   <= 1'b0;
      doneChar <= 1'b0;
      case (state)
        IDLE: if (req) begin
          anc_x <= xCoordinate;
          anc_y <= yCoordinate;
          src   <= drawBG ? SRC_BG : SRC_CHAR;
          state <= SCAN;
        end
        SCAN: if (last) begin
          flush_cnt <= 1'b0;
          state     <= FLUSH;
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= DONE;
        end
        DONE: begin
          doneBG   <= (src == SRC_BG);
          doneChar <= (src == SRC_CHAR);
          state    <= HOLD;
        end
        // Mover may still hold its request after done; wait for release.
        HOLD: if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic       s1_vld, s1_on, s2_vld, s2_on;
  logic [8:0] s1_x, s2_x;
  logic [7:0] s1_y, s2_y;
  logic       hide;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [COLOUR_W-1:0] TRANSP_C = COLOUR_W'(TRANSPARENT);
  assign hide = (src == SRC_CHAR) && (spr_data == TRANSP_C);
`else
  assign hide = 1'b0;
`endif

  // Stage 1 issues the ROM address, stage 2 waits for ROM data, stage 3 registers the plot.
  always_ff @(posedge clock) begin
    if (reset) begin
      bg_addr    <= '0;
      spr_addr   <= '0;
      s1_vld     <= 1'b0;
      s1_on      <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s2_vld     <= 1'b0;
      s2_on      <= 1'b0;
      s2_x       <= '0;
      s2_y       <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
    end else begin
      s1_vld <= scanning;
      if (scanning) begin
        s1_on    <= pix_on;
        s1_x     <= px[8:0];
        s1_y     <= py[7:0];
        bg_addr  <= pix_on ? BG_ADDR_W'(py[7:0]) * BG_ADDR_W'(SCREEN_W) + BG_ADDR_W'(px[8:0])
                           : '0;
        spr_addr <= {row, col};
      end
      s2_vld <= s1_vld;
      s2_on  <= s1_on;
      s2_x   <= s1_x;
      s2_y   <= s1_y;
      plot   <= s2_vld && s2_on && !hide;
      if (s2_vld) begin
        vga_x      <= s2_x;
        vga_y      <= s2_y;
        vga_colour <= (src == SRC_CHAR) ? spr_data : bg_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed scoreboard bench for sprite_draw_engine with a 4x4 sprite (anchors 0 and 2).
module tb_sprite_draw_engine;
  import sprite_draw_pkg::*;

  localparam int N = 16;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TR_EN = 1'b1;
`else
  localparam bit TR_EN = 1'b0;
`endif

  typedef struct packed {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] c;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       rb0 = 1'b0, rc0 = 1'b0, rb1 = 1'b0, rc1 = 1'b0;
  logic [8:0] xc = '0;
  logic [7:0] yc = '0;
  bit         tr_mode = 1'b0;
  bit         sel = 1'b0;

  logic        done_bg0, done_ch0, plot0, done_bg1, done_ch1, plot1;
  logic [16:0] bg_addr0, bg_addr1;
  logic [8:0]  bg_data0 = '0, bg_data1 = '0, spr_data0 = '0, spr_data1 = '0;
  logic [3:0]  spr_addr0, spr_addr1;
  logic [8:0]  vx0, vx1, vc0, vc1;
  logic [7:0]  vy0, vy1;

  sprite_draw_engine #(.SPR_W(4), .SPR_H(4), .ANCHOR_X(0), .ANCHOR_Y(0),
                       .COLOUR_W(9), .TRANSPARENT('h1FF)) dut0 (
    .clock(clock), .reset(reset), .drawBG(rb0), .drawChar(rc0),
    .xCoordinate(xc), .yCoordinate(yc), .doneBG(done_bg0), .doneChar(done_ch0),
    .bg_addr(bg_addr0), .bg_data(bg_data0), .spr_addr(spr_addr0), .spr_data(spr_data0),
    .vga_x(vx0), .vga_y(vy0), .vga_colour(vc0), .plot(plot0));

  sprite_draw_engine #(.SPR_W(4), .SPR_H(4), .ANCHOR_X(2), .ANCHOR_Y(2),
                       .COLOUR_W(9), .TRANSPARENT('h1FF)) dut1 (
    .clock(clock), .reset(reset), .drawBG(rb1), .drawChar(rc1),
    .xCoordinate(xc), .yCoordinate(yc), .doneBG(done_bg1), .doneChar(done_ch1),
    .bg_addr(bg_addr1), .bg_data(bg_data1), .spr_addr(spr_addr1), .spr_data(spr_data1),
    .vga_x(vx1), .vga_y(vy1), .vga_colour(vc1), .plot(plot1));

  function automatic logic [8:0] bg_fn(input logic [16:0] a);
    return a[8:0] ^ a[16:8] ^ 9'h0AA;
  endfunction

  function automatic logic [8:0] spr_fn(input logic [3:0] a, input bit tr);
    return (tr && !a[0]) ? 9'h1FF : {5'h0A, a};
  endfunction

  always @(posedge clock) begin
    bg_data0  <= bg_fn(bg_addr0);
    bg_data1  <= bg_fn(bg_addr1);
    spr_data0 <= spr_fn(spr_addr0, tr_mode);
    spr_data1 <= spr_fn(spr_addr1, tr_mode);
  end

  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   nbg = 0, nchar = 0, nplot = 0, done_cyc = -1;
  exp_t sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  logic       m_plot, m_dbg, m_dch;
  logic [8:0] m_x, m_c;
  logic [7:0] m_y;
  assign m_plot = sel ? plot1 : plot0;
  assign m_dbg  = sel ? done_bg1 : done_bg0;
  assign m_dch  = sel ? done_ch1 : done_ch0;
  assign m_x    = sel ? vx1 : vx0;
  assign m_y    = sel ? vy1 : vy0;
  assign m_c    = sel ? vc1 : vc0;

  always @(negedge clock) begin
    exp_t e;
    if (m_dbg) begin nbg++;   done_cyc = cyc; end
    if (m_dch) begin nchar++; done_cyc = cyc; end
    if (m_plot) begin
      nplot++;
      chk("plot_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("plot_cycle", 64'(cyc), 64'(e.cyc));
        chk("plot_x", 64'(m_x), 64'(e.x));
        chk("plot_y", 64'(m_y), 64'(e.y));
        chk("plot_colour", 64'(m_c), 64'(e.c));
      end
    end
  end

  task automatic push_exp(input bit chr, input int x, input int y, input int ax, input int ay,
                          input int e0, input int maxi, output int pushed);
    pushed = 0;
    for (int i = 0; i < maxi; i++) begin
      int   px, py;
      exp_t e;
      px = x - ax + (i % 4);
      py = y - ay + (i / 4);
      if (px < 0 || px > 319 || py < 0 || py > 239) continue;
      if (chr && tr_mode && TR_EN && (i % 2 == 0)) continue;
      e.cyc = e0 + 3 + i;
      e.x   = px[8:0];
      e.y   = py[7:0];
      e.c   = chr ? spr_fn(4'(i), tr_mode) : bg_fn(17'(py * 320 + px));
      sb.push_back(e);
      pushed++;
    end
  endtask

  task automatic set_req(input bit dsel, input bit rb, input bit rc);
    if (dsel) begin rb1 = rb; rc1 = rc; end
    else      begin rb0 = rb; rc0 = rc; end
  endtask

  // Called at a negedge: the next posedge is E0.
  task automatic run_scan(input string tag, input bit dsel, input bit rb, input bit rc,
                          input int x, input int y, input int exp_addr, input int exp_plots);
    int e0, pushed, ax;
    ax = dsel ? 2 : 0;
    sel = dsel; nbg = 0; nchar = 0; nplot = 0; done_cyc = -1;
    e0 = cyc + 1;
    push_exp(rc && !rb, x, y, ax, ax, e0, N, pushed);
    xc = 9'(x); yc = 8'(y);
    set_req(dsel, rb, rc);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    xc = xc + 9'd5;
    yc = yc + 8'd3;
    if (exp_addr >= 0) chk({tag, "_first_bg_addr"}, 64'(bg_addr0), 64'(exp_addr));
    for (int k = 0; k < 60 && (nbg + nchar) == 0; k++) @(negedge clock);
    chk({tag, "_done_seen"}, 64'((nbg + nchar) != 0), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(e0 + N + 3));
    repeat (4) @(negedge clock);
    set_req(dsel, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk({tag, "_doneBG_count"}, 64'(nbg), 64'(rb ? 1 : 0));
    chk({tag, "_doneChar_count"}, 64'(nchar), 64'(rb ? 0 : 1));
    chk({tag, "_plot_count"}, 64'(nplot), 64'(exp_plots));
    chk({tag, "_plots_pushed"}, 64'(nplot), 64'(pushed));
    chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle"}, 64'(dsel ? dut1.state : dut0.state), 64'(IDLE));
  endtask

  initial begin
    int e0, pushed;
    repeat (3) @(negedge clock);
    chk("rst_plot", 64'(plot0), 64'd0);
    chk("rst_doneBG", 64'(done_bg0), 64'd0);
    chk("rst_doneChar", 64'(done_ch0), 64'd0);
    chk("rst_vga", 64'({vx0, vy0, vc0}), 64'd0);
    chk("rst_addr", 64'({bg_addr0, spr_addr0}), 64'd0);
    chk("rst_state", 64'(dut0.state), 64'(IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_scan("bg96", 1'b0, 1'b1, 1'b0, 96, 100, 32096, 16);
    run_scan("char_clip_tl", 1'b1, 1'b0, 1'b1, 0, 0, -1, 4);
    run_scan("char_clip_br", 1'b0, 1'b0, 1'b1, 318, 238, -1, 4);
    run_scan("both", 1'b0, 1'b1, 1'b1, 50, 60, 19250, 16);

    // Reset lands at edge E0+8: five plots go out, then nothing.
    sel = 1'b0; nbg = 0; nchar = 0; nplot = 0;
    e0 = cyc + 1;
    push_exp(1'b1, 10, 10, 0, 0, e0, 5, pushed);
    xc = 9'd10; yc = 8'd10; rc0 = 1'b1;
    while (cyc < e0 + 7) @(negedge clock);
    reset = 1'b1; rc0 = 1'b0;
    @(negedge clock);
    chk("midrst_plot", 64'(plot0), 64'd0);
    chk("midrst_state", 64'(dut0.state), 64'(IDLE));
    reset = 1'b0;
    repeat (25) @(negedge clock);
    chk("midrst_no_done", 64'(nbg + nchar), 64'd0);
    chk("midrst_plots", 64'(nplot), 64'(pushed));
    chk("midrst_sb", 64'(sb.size()), 64'd0);
    run_scan("after_rst", 1'b0, 1'b0, 1'b1, 40, 30, -1, 16);

    tr_mode = 1'b1;
    run_scan("transp", 1'b0, 1'b0, 1'b1, 20, 20, -1, TR_EN ? 8 : 16);
    tr_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
